pic_ack_arbiter: RTL and testbench

Clocked request arbiter and acknowledge sequencer for the interrupt controller. Latches edge-triggered requests into IRR, resolves the highest-priority unmasked request against the in-service set (fully nested), drives INT, and runs the two-pulse INTA handshake that moves the winner from IRR to ISR and returns the 8-bit vector. Sits between the request inputs, the ICW/OCW register file (mask, vector base) and the data bus buffer.

---
 rtl/pic_ack_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_pic_ack_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pic_ack_arbiter.sv
// Interrupt request latch, fully nested priority resolver and two-pulse INTA sequencer.
// Optional PIC_AUTO_ROTATE_EN: each EOI makes the level it cleared the new lowest priority.
module pic_ack_arbiter #(
    parameter logic [2:0] SPURIOUS_LVL = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic [7:0] imr,
    input  logic [4:0] vec_base,
    input  logic       inta_n,
    input  logic       eoi,
    output logic       int_o,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic [7:0] irr,
    output logic [7:0] isr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  ir_prev_q;
    logic        inta_prev_q;
    logic [7:0]  irr_q, irr_d;
    logic [7:0]  isr_q, isr_d;
    logic [2:0]  sel_q, sel_d;
    logic        spur_q, spur_d;
    logic        int_q, int_d;
    logic [7:0]  vec_q, vec_d;
    logic        vv_q, vv_d;
    logic [2:0]  lp_s;

    logic [7:0]  elig_s;
    logic [3:0]  elig_pick_s;
    logic [3:0]  isr_pick_s;
    logic        win_s;
    logic        inta_fall_s;
    logic        ack1_go_s;
    logic        ack2_go_s;
    logic        ack2_done_s;

    // {hit, level} of the highest-priority set bit; level lp_v+1 is highest, lp_v lowest.
    function automatic logic [3:0] prio_pick(input logic [7:0] bits, input logic [2:0] lp_v);
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'd0;
        for (int k = 0; k < 8; k++) begin
            lvl = lp_v - 3'(k);
            if (bits[lvl]) begin
                res = {1'b1, lvl};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // 0 = highest priority, 7 = lowest.
    function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lp_v);
        return lvl - lp_v - 3'd1;
    endfunction

`ifdef PIC_AUTO_ROTATE_EN
    logic [2:0] lp_q, lp_d;
    assign lp_s = lp_q;
`else
    assign lp_s = 3'd7;
`endif

    assign elig_s      = irr_q & ~imr;
    assign elig_pick_s = prio_pick(elig_s, lp_s);
    assign isr_pick_s  = prio_pick(isr_q, lp_s);
    assign win_s       = elig_pick_s[3] &&
                         (!isr_pick_s[3] ||
                          (prio_rank(elig_pick_s[2:0], lp_s) < prio_rank(isr_pick_s[2:0], lp_s)));

    assign inta_fall_s = ~inta_n & inta_prev_q;
    assign ack1_go_s   = (state_q == IDLE) && inta_fall_s;
    assign ack2_go_s   = (state_q == ACK1) && inta_fall_s;
    assign ack2_done_s = (state_q == ACK2) && inta_n;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; stray INTA edges in ACK2 fall through to the hold.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ack1_go_s   ? ACK1 : IDLE;
            ACK1:    state_d = ack2_go_s   ? ACK2 : ACK1;
            ACK2:    state_d = ack2_done_s ? IDLE : ACK2;
            default: state_d = IDLE;
        endcase
    end

    // Output and register-file next values.
    always_comb begin
        irr_d  = irr_q;
        isr_d  = isr_q;
        sel_d  = sel_q;
        spur_d = spur_q;
        vec_d  = vec_q;
        vv_d   = vv_q;
`ifdef PIC_AUTO_ROTATE_EN
        lp_d   = lp_q;
`endif

        // EOI acts on the pre-existing ISR before any same-edge acknowledge sets a bit.
        if (eoi && isr_pick_s[3]) begin
            isr_d[isr_pick_s[2:0]] = 1'b0;
`ifdef PIC_AUTO_ROTATE_EN
            lp_d = isr_pick_s[2:0];
`endif
        end else begin
            isr_d = isr_q;
        end

        if (ack1_go_s) begin
            if (win_s) begin
                sel_d                   = elig_pick_s[2:0];
                spur_d                  = 1'b0;
                isr_d[elig_pick_s[2:0]] = 1'b1;
                irr_d[elig_pick_s[2:0]] = 1'b0;
            end else begin
                sel_d  = SPURIOUS_LVL;
                spur_d = 1'b1;
            end
        end else begin
            sel_d  = sel_q;
            spur_d = spur_q;
        end

        // A new rising edge beats a same-cycle acknowledge clear.
        irr_d = irr_d | (ir & ~ir_prev_q);

        int_d = (state_q == IDLE) && !inta_fall_s && win_s;

        if (ack2_go_s) begin
            vec_d = {vec_base, (spur_q ? SPURIOUS_LVL : sel_q)};
            vv_d  = 1'b1;
        end else if (ack2_done_s) begin
            vv_d  = 1'b0;
        end else begin
            vv_d  = vv_q;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_prev_q   <= 8'h00;
            inta_prev_q <= 1'b1;
            irr_q       <= 8'h00;
            isr_q       <= 8'h00;
            sel_q       <= 3'd0;
            spur_q      <= 1'b0;
            int_q       <= 1'b0;
            vec_q       <= 8'h00;
            vv_q        <= 1'b0;
`ifdef PIC_AUTO_ROTATE_EN
            lp_q        <= 3'd7;
`endif
        end else begin
            ir_prev_q   <= ir;
            inta_prev_q <= inta_n;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            sel_q       <= sel_d;
            spur_q      <= spur_d;
            int_q       <= int_d;
            vec_q       <= vec_d;
            vv_q        <= vv_d;
`ifdef PIC_AUTO_ROTATE_EN
            lp_q        <= lp_d;
`endif
        end
    end

    assign int_o        = int_q;
    assign vector       = vec_q;
    assign vector_valid = vv_q;
    assign irr          = irr_q;
    assign isr          = isr_q;

endmodule

// File: tb/tb_pic_ack_arbiter.sv
// Scoreboard bench for pic_ack_arbiter: expectations are queued with each stimulus step
// and compared one cycle later, #1 after the rising edge.
module tb_pic_ack_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ir;
    logic [7:0] imr;
    logic [4:0] vec_base;
    logic       inta_n;
    logic       eoi;
    logic       int_o;
    logic [7:0] vector;
    logic       vector_valid;
    logic [7:0] irr;
    logic [7:0] isr;

    always #5 clk = ~clk;

    pic_ack_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir           (ir),
        .imr          (imr),
        .vec_base     (vec_base),
        .inta_n       (inta_n),
        .eoi          (eoi),
        .int_o        (int_o),
        .vector       (vector),
        .vector_valid (vector_valid),
        .irr          (irr),
        .isr          (isr)
    );

    localparam int S_INT = 0;
    localparam int S_IRR = 1;
    localparam int S_ISR = 2;
    localparam int S_VEC = 3;
    localparam int S_VV  = 4;

    typedef struct {
        string      tag;
        int         sig;
        logic [7:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] observe(input int sig);
        case (sig)
            S_INT:   return {7'd0, int_o};
            S_IRR:   return irr;
            S_ISR:   return isr;
            S_VEC:   return vector;
            S_VV:    return {7'd0, vector_valid};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input logic [7:0] exp);
        sb_q.push_back('{tag, sig, exp});
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sig), e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ir     = 8'h00;
        imr    = 8'h00;
        inta_n = 1'b1;
        eoi    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic ir_pulse(input string t, input logic [7:0] lines, input logic [7:0] irr_exp);
        ir = lines;
        push({t, "_irr"}, S_IRR, irr_exp);
        push({t, "_int_lat"}, S_INT, 8'h00);
        step();
        ir = 8'h00;
        push({t, "_int"}, S_INT, 8'h01);
        step();
    endtask

    task automatic ack_pair(input string t, input logic [7:0] isr_exp,
                            input logic [7:0] irr_exp, input logic [7:0] vec_exp);
        inta_n = 1'b0;
        push({t, "_isr"}, S_ISR, isr_exp);
        push({t, "_irr"}, S_IRR, irr_exp);
        push({t, "_int_ack"}, S_INT, 8'h00);
        step();
        inta_n = 1'b1;
        step();
        inta_n = 1'b0;
        push({t, "_vec"}, S_VEC, vec_exp);
        push({t, "_vv1"}, S_VV, 8'h01);
        step();
        inta_n = 1'b1;
        push({t, "_vv0"}, S_VV, 8'h00);
        step();
    endtask

    task automatic eoi_pulse(input string t, input logic [7:0] isr_exp);
        eoi = 1'b1;
        push({t, "_isr"}, S_ISR, isr_exp);
        step();
        eoi = 1'b0;
    endtask

    initial begin
        vec_base = 5'h08;
        do_reset();
        push("rst_int", S_INT, 8'h00);
        push("rst_irr", S_IRR, 8'h00);
        push("rst_isr", S_ISR, 8'h00);
        push("rst_vec", S_VEC, 8'h00);
        push("rst_vv", S_VV, 8'h00);
        drain();

        // Single IR3 request through the full handshake.
        ir_pulse("t1", 8'h08, 8'h08);
        ack_pair("t1", 8'h08, 8'h00, 8'h43);
        push("t1_int_idle", S_INT, 8'h00);
        step();

        // Nesting: IR2 interrupts IR5 in service, EOI clears IR2.
        do_reset();
        ir_pulse("t2a", 8'h20, 8'h20);
        ack_pair("t2a", 8'h20, 8'h00, 8'h45);
        push("t2_int_idle", S_INT, 8'h00);
        step();
        ir_pulse("t2b", 8'h04, 8'h04);
        ack_pair("t2b", 8'h24, 8'h00, 8'h42);
        eoi_pulse("t2_eoi", 8'h20);

        // Request masked before the acknowledge: spurious vector.
        do_reset();
        ir_pulse("t3", 8'h40, 8'h40);
        imr = 8'h40;
        push("t3_int_mask", S_INT, 8'h00);
        step();
        ack_pair("t3", 8'h00, 8'h40, 8'h47);
        push("t3_int_after", S_INT, 8'h00);
        step();
        imr = 8'h00;

        // Simultaneous IR1/IR4, then IR0/IR4.
        do_reset();
        ir_pulse("t4a", 8'h12, 8'h12);
        ack_pair("t4a", 8'h02, 8'h10, 8'h41);
        push("t4_int_blocked", S_INT, 8'h00);
        step();
        eoi_pulse("t4a_eoi", 8'h00);
        push("t4_int_ir4", S_INT, 8'h01);
        step();
        ack_pair("t4b", 8'h10, 8'h00, 8'h44);
        eoi_pulse("t4b_eoi", 8'h00);
        ir_pulse("t4c", 8'h11, 8'h11);
        ack_pair("t4c", 8'h01, 8'h10, 8'h40);

        // Reset between the two INTA pulses, then a lone INTA.
        do_reset();
        ir_pulse("t5", 8'h08, 8'h08);
        inta_n = 1'b0;
        push("t5_isr", S_ISR, 8'h08);
        step();
        inta_n = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        push("t5_rst_int", S_INT, 8'h00);
        push("t5_rst_irr", S_IRR, 8'h00);
        push("t5_rst_isr", S_ISR, 8'h00);
        push("t5_rst_vec", S_VEC, 8'h00);
        push("t5_rst_vv", S_VV, 8'h00);
        drain();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        inta_n = 1'b0;
        push("t5_lone_isr", S_ISR, 8'h00);
        step();
        inta_n = 1'b1;
        step();
        push("t5_lone_vv", S_VV, 8'h00);
        push("t5_lone_vec", S_VEC, 8'h00);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
